// File: rtl/tlb_array.sv
`default_nettype none
// ============================================================================
// Module   : tlb_array
// Brief    : Fully associative TLB with two search ports, a probe port, a
//            write port and a combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_array #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s0_req,
    input  logic [18:0]             s0_vpn2,
    input  logic                    s0_odd,
    input  logic [7:0]              s0_asid,
    output logic                    s0_rvalid,
    output logic                    s0_found,
    output logic [TLBNUM_WIDTH-1:0] s0_index,
    output logic [19:0]             s0_pfn,
    output logic [2:0]              s0_c,
    output logic                    s0_d,
    output logic                    s0_v,
    input  logic                    s1_req,
    input  logic [18:0]             s1_vpn2,
    input  logic                    s1_odd,
    input  logic [7:0]              s1_asid,
    output logic                    s1_rvalid,
    output logic                    s1_found,
    output logic [TLBNUM_WIDTH-1:0] s1_index,
    output logic [19:0]             s1_pfn,
    output logic [2:0]              s1_c,
    output logic                    s1_d,
    output logic                    s1_v,
    input  logic                    p_req,
    input  logic [18:0]             p_vpn2,
    input  logic [7:0]              p_asid,
    output logic                    p_rvalid,
    output logic [TLBNUM_WIDTH:0]   p_result,
    input  logic                    w_we,
    input  logic [TLBNUM_WIDTH-1:0] w_index,
    input  logic [18:0]             w_vpn2,
    input  logic [7:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_pfn0,
    input  logic [2:0]              w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [19:0]             w_pfn1,
    input  logic [2:0]              w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,
    input  logic [TLBNUM_WIDTH-1:0] r_index,
    output logic [18:0]             r_vpn2,
    output logic [7:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_pfn0,
    output logic [2:0]              r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [19:0]             r_pfn1,
    output logic [2:0]              r_c1,
    output logic                    r_d1,
    output logic                    r_v1
);

    logic [18:0]       vpn2_q [TLBNUM];
    logic [7:0]        asid_q [TLBNUM];
    logic              g_q    [TLBNUM];
    logic [19:0]       pfn0_q [TLBNUM];
    logic [2:0]        c0_q   [TLBNUM];
    logic              d0_q   [TLBNUM];
    logic              v0_q   [TLBNUM];
    logic [19:0]       pfn1_q [TLBNUM];
    logic [2:0]        c1_q   [TLBNUM];
    logic              d1_q   [TLBNUM];
    logic              v1_q   [TLBNUM];
    logic [TLBNUM-1:0] e_q;

    // Only the exist bits are reset; entry payload survives reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q <= '0;
        end else if (w_we) begin
            e_q[w_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            vpn2_q[w_index] <= w_vpn2;
            asid_q[w_index] <= w_asid;
            g_q[w_index]    <= w_g;
            pfn0_q[w_index] <= w_pfn0;
            c0_q[w_index]   <= w_c0;
            d0_q[w_index]   <= w_d0;
            v0_q[w_index]   <= w_v0;
            pfn1_q[w_index] <= w_pfn1;
            c1_q[w_index]   <= w_c1;
            d1_q[w_index]   <= w_d1;
            v1_q[w_index]   <= w_v1;
        end
    end

    assign r_vpn2 = vpn2_q[r_index];
    assign r_asid = asid_q[r_index];
    assign r_g    = g_q[r_index];
    assign r_pfn0 = pfn0_q[r_index];
    assign r_c0   = c0_q[r_index];
    assign r_d0   = d0_q[r_index];
    assign r_v0   = v0_q[r_index];
    assign r_pfn1 = pfn1_q[r_index];
    assign r_c1   = c1_q[r_index];
    assign r_d1   = d1_q[r_index];
    assign r_v1   = v1_q[r_index];

    // Returns {miss, index}; scanning downward lets the lowest match win.
    function automatic logic [TLBNUM_WIDTH:0] lookup(input logic [18:0] vpn2,
                                                     input logic [7:0]  asid);
        logic [TLBNUM_WIDTH:0] res;
        res = {1'b1, {TLBNUM_WIDTH{1'b0}}};
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (e_q[i] && (vpn2_q[i] == vpn2) && (g_q[i] || (asid_q[i] == asid))) begin
                res = {1'b0, TLBNUM_WIDTH'(i)};
            end
        end
        return res;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_search
        logic                    req;
        logic                    odd;
        logic [18:0]             vpn2;
        logic [7:0]              asid;
        logic [TLBNUM_WIDTH:0]   hit_d;
        logic [TLBNUM_WIDTH-1:0] idx_d;
        logic                    rvalid_q;
        logic                    found_q;
        logic [TLBNUM_WIDTH-1:0] index_q;
        logic [19:0]             pfn_q;
        logic [2:0]              c_q;
        logic                    d_q;
        logic                    v_q;

        assign req   = (k == 0) ? s0_req  : s1_req;
        assign odd   = (k == 0) ? s0_odd  : s1_odd;
        assign vpn2  = (k == 0) ? s0_vpn2 : s1_vpn2;
        assign asid  = (k == 0) ? s0_asid : s1_asid;
        assign hit_d = lookup(vpn2, asid);
        assign idx_d = hit_d[TLBNUM_WIDTH-1:0];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rvalid_q <= 1'b0;
                found_q  <= 1'b0;
                index_q  <= '0;
                pfn_q    <= '0;
                c_q      <= '0;
                d_q      <= 1'b0;
                v_q      <= 1'b0;
            end else begin
                rvalid_q <= req;
                if (req) begin
                    found_q <= ~hit_d[TLBNUM_WIDTH];
                    if (hit_d[TLBNUM_WIDTH]) begin
                        index_q <= '0;
                        pfn_q   <= '0;
                        c_q     <= '0;
                        d_q     <= 1'b0;
                        v_q     <= 1'b0;
                    end else begin
                        index_q <= idx_d;
                        pfn_q   <= odd ? pfn1_q[idx_d] : pfn0_q[idx_d];
                        c_q     <= odd ? c1_q[idx_d]   : c0_q[idx_d];
                        d_q     <= odd ? d1_q[idx_d]   : d0_q[idx_d];
                        v_q     <= odd ? v1_q[idx_d]   : v0_q[idx_d];
                    end
                end
            end
        end
    end

    assign s0_rvalid = g_search[0].rvalid_q;
    assign s0_found  = g_search[0].found_q;
    assign s0_index  = g_search[0].index_q;
    assign s0_pfn    = g_search[0].pfn_q;
    assign s0_c      = g_search[0].c_q;
    assign s0_d      = g_search[0].d_q;
    assign s0_v      = g_search[0].v_q;
    assign s1_rvalid = g_search[1].rvalid_q;
    assign s1_found  = g_search[1].found_q;
    assign s1_index  = g_search[1].index_q;
    assign s1_pfn    = g_search[1].pfn_q;
    assign s1_c      = g_search[1].c_q;
    assign s1_d      = g_search[1].d_q;
    assign s1_v      = g_search[1].v_q;

    logic                  p_rvalid_q;
    logic [TLBNUM_WIDTH:0] p_result_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_rvalid_q <= 1'b0;
            p_result_q <= '0;
        end else begin
            p_rvalid_q <= p_req;
            if (p_req) begin
                p_result_q <= lookup(p_vpn2, p_asid);
            end
        end
    end

    assign p_rvalid = p_rvalid_q;
    assign p_result = p_result_q;

endmodule
`default_nettype wire

// File: doc/tlb_array.md
TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of entries (power of two, 2..32).
REQ-002 SHALL have parameter TLBNUM_WIDTH, default $clog2(TLBNUM), index width.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- s0_req / s1_req  in  1  search request (s0 = fetch, s1 = data)
- s0_vpn2 / s1_vpn2  in  19  VA[31:13]
- s0_odd / s1_odd  in  1  VA[12]
- s0_asid / s1_asid  in  8  ASID
- s0_rvalid / s1_rvalid  out  1  result valid
- s0_found / s1_found  out  1  hit
- s0_index / s1_index  out  TLBNUM_WIDTH  hit entry
- s0_pfn / s1_pfn  out  20  PFN of selected page
- s0_c / s1_c  out  3  cache attribute
- s0_d / s1_d  out  1  dirty
- s0_v / s1_v  out  1  valid
- p_req  in  1  TLBP probe request
- p_vpn2  in  19  probe VPN2
- p_asid  in  8  probe ASID
- p_rvalid  out  1  probe result valid
- p_result  out  TLBNUM_WIDTH+1  {P (1 = miss), index}
- w_we  in  1  write enable (TLBWI/TLBWR)
- w_index  in  TLBNUM_WIDTH  write entry
- w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  in  19/8/1/20/3/1/1/20/3/1/1  entry contents
- r_index  in  TLBNUM_WIDTH  read entry
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  as w_*  entry contents

Function
REQ-004 Each entry SHALL hold vpn2, asid, g, pfn0/c0/d0/v0, pfn1/c1/d1/v1, plus a hidden exist bit E.
REQ-005 Write: when w_we=1 at a rising edge, entry w_index SHALL be loaded with all w_* fields and E set to 1; visible from the next cycle.
REQ-006 Read port SHALL be combinational from stored state: r_* = entry[r_index] fields, zero-latency, no write bypass.
REQ-007 Entry i SHALL match a query when E_i=1 and vpn2_i==query vpn2 and (g_i=1 or asid_i==query asid); the V bits SHALL NOT affect matching.
REQ-008 Multiple matches SHALL resolve to the lowest index.
REQ-009 Search ports SHALL have 1-cycle latency: request sampled at edge N; registered results valid from edge N+1 until edge N+2.
REQ-010 sX_rvalid SHALL equal sX_req delayed by one cycle; a new request may be issued every cycle (fully pipelined, no stall).
REQ-011 On hit: sX_found=1, sX_index=hit index, and {pfn,c,d,v} SHALL be taken from page 1 if sX_odd=1, else page 0.
REQ-012 On miss: sX_found=0, and sX_index, pfn, c, d, v SHALL be 0.
REQ-013 When sX_req=0, sX_rvalid SHALL be 0 and the other sX result outputs SHALL hold their previous values.
REQ-014 Probe SHALL follow the same 1-cycle timing via p_rvalid; p_result = {1'b0, index} on hit and {1'b1, 0} on miss.
REQ-015 A search or probe sampled at the same edge as a write SHALL see the pre-write contents (no forwarding).
REQ-016 s0, s1, probe and write SHALL operate concurrently and independently every cycle.

Reset
REQ-017 resetn=0 SHALL asynchronously clear all E bits and all registered outputs (rvalid, found, index, pfn, c, d, v, p_result) to 0.
REQ-018 Entry fields other than E are not reset; r_* SHALL reflect stored contents regardless of E.
REQ-019 A request in flight when reset asserts SHALL be discarded; the first request after deassertion SHALL complete normally.

Verification
REQ-020 After reset, s0 query vpn2=0, asid=0 -> next cycle s0_rvalid=1, s0_found=0, s0_index=0; p query -> p_result=5'h10.
REQ-021 Write idx 3 {vpn2=19'h00123, asid=8'h05, g=0, pfn1=20'hABCDE, c1=3, d1=1, v1=1}; s1 query vpn2=19'h00123, odd=1, asid=5 -> found=1, index=3, pfn=20'hABCDE, c=3, d=1, v=1; asid=6 -> found=0.
REQ-022 Same entry rewritten with g=1 -> query asid=8'hFF -> found=1; write to idx 3 and query sampled at the same edge -> old result; query one cycle later -> new result.
REQ-023 Identical vpn2/asid written to idx 7 and idx 2 -> s0 and probe both report index 2, p_result=5'h02.
REQ-024 Back-to-back s0 requests on 3 consecutive cycles (hit, miss, hit) -> rvalid high for 3 cycles with matching per-cycle results; resetn pulsed low mid-stream -> outputs 0 immediately and all entries miss afterwards.
